// File: rtl/uart_pkg.sv
// Shared types and helpers for the configurable UART receiver.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_BREAK
  } state_e;

  localparam int unsigned PAR_NONE = 0;
  localparam int unsigned PAR_EVEN = 1;
  localparam int unsigned PAR_ODD  = 2;

  // Expected parity bit over up to 9 data bits; unused upper bits must be zero.
  function automatic logic parity_bit(input logic [8:0] data, input logic odd);
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/uart_rx_cfg_if.sv
// Serial input and received-word outputs of the UART receiver.
interface uart_rx_cfg_if #(
  parameter int unsigned DATA_BITS = 8
);
  logic                 RX;
  logic [DATA_BITS-1:0] oData;
  logic                 oValid;
  logic                 oParityErr;
  logic                 oFrameErr;
  logic                 oBusy;

  modport master (
    input  RX,
    output oData, oValid, oParityErr, oFrameErr, oBusy
  );

  modport slave (
    output RX,
    input  oData, oValid, oParityErr, oFrameErr, oBusy
  );
endinterface

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous input.
module sync_2ff #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);
  logic meta;

  always_ff @(posedge clk) begin
    if (reset) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end
endmodule

// File: rtl/uart_rx_cfg.sv
// Oversampling UART receiver with configurable framing, majority-vote bit
// decisions, start-glitch rejection and parity/framing error reporting.
module uart_rx_cfg
  import uart_pkg::*;
#(
  parameter int unsigned DIVIDER    = 16,
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned PARITY     = 0,
  parameter int unsigned STOP_BITS  = 1,
  parameter int unsigned VALID_HOLD = 10
) (
  input logic           clk,
  input logic           reset,
  uart_rx_cfg_if.master bus
);
  localparam int unsigned STEP_W = $clog2(DIVIDER);
  localparam int unsigned IDX_W  = $clog2(DATA_BITS);
  localparam int unsigned HOLD_W = $clog2(VALID_HOLD + 1);

  localparam logic [STEP_W-1:0] START_LAST = STEP_W'(DIVIDER / 2 - 1);
  localparam logic [STEP_W-1:0] SAMP_A     = STEP_W'(DIVIDER - 3);
  localparam logic [STEP_W-1:0] SAMP_B     = STEP_W'(DIVIDER - 2);
  localparam logic [STEP_W-1:0] STEP_LAST  = STEP_W'(DIVIDER - 1);
  localparam logic [IDX_W-1:0]  DATA_LAST  = IDX_W'(DATA_BITS - 1);
  localparam logic [IDX_W-1:0]  STOP_LAST  = IDX_W'(STOP_BITS - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST  = HOLD_W'(VALID_HOLD - 1);

  if ((DIVIDER % 2) != 0 || DIVIDER < 4 || DATA_BITS < 5 || DATA_BITS > 9 ||
      PARITY > PAR_ODD || (STOP_BITS != 1 && STOP_BITS != 2) || VALID_HOLD < 1)
  begin : g_param_check
    $error("uart_rx_cfg: illegal parameter combination");
  end

  state_e                 state, state_n;
  logic [STEP_W-1:0]      stepcnt, stepcnt_n;
  logic [IDX_W-1:0]       bitidx, bitidx_n;
  logic [DATA_BITS-1:0]   shreg, shreg_n;
  logic [1:0]             samp, samp_n;
  logic                   perr, perr_n;
  logic                   irx;
  logic                   maj;
  logic                   bit_done;
  logic                   accept_c;
  logic                   ferr_c;
  logic                   accept_q;
  logic [HOLD_W-1:0]      holdcnt;

  sync_2ff #(.RESET_VAL(1'b1)) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (bus.RX),
    .q     (irx)
  );

  // Two early samples are registered; the third is the live input at the decision point.
  assign maj = (samp[0] & samp[1]) | (samp[0] & irx) | (samp[1] & irx);

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= ST_IDLE;
      stepcnt <= '0;
      bitidx  <= '0;
      shreg   <= '0;
      samp    <= 2'b00;
      perr    <= 1'b0;
    end else begin
      state   <= state_n;
      stepcnt <= stepcnt_n;
      bitidx  <= bitidx_n;
      shreg   <= shreg_n;
      samp    <= samp_n;
      perr    <= perr_n;
    end
  end

  always_comb begin
    state_n   = state;
    stepcnt_n = stepcnt;
    bitidx_n  = bitidx;
    shreg_n   = shreg;
    samp_n    = samp;
    perr_n    = perr;
    bit_done  = 1'b0;
    accept_c  = 1'b0;
    ferr_c    = 1'b0;

    if (state inside {ST_DATA, ST_PARITY, ST_STOP}) begin
      if (stepcnt == SAMP_A) samp_n[0] = irx;
      if (stepcnt == SAMP_B) samp_n[1] = irx;
      if (stepcnt == STEP_LAST) begin
        stepcnt_n = '0;
        bit_done  = 1'b1;
      end else begin
        stepcnt_n = stepcnt + STEP_W'(1);
      end
    end

    unique case (state)
      ST_IDLE: begin
        if (!irx) begin
          state_n   = ST_START;
          stepcnt_n = STEP_W'(1);
          perr_n    = 1'b0;
        end
      end
      ST_START: begin
        if (irx) begin
          state_n   = ST_IDLE;
          stepcnt_n = '0;
        end else if (stepcnt == START_LAST) begin
          state_n   = ST_DATA;
          stepcnt_n = '0;
          bitidx_n  = '0;
        end else begin
          stepcnt_n = stepcnt + STEP_W'(1);
        end
      end
      ST_DATA: begin
        if (bit_done) begin
          shreg_n[bitidx] = maj;
          if (bitidx == DATA_LAST) begin
            bitidx_n = '0;
            state_n  = (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
          end else begin
            bitidx_n = bitidx + IDX_W'(1);
          end
        end
      end
      ST_PARITY: begin
        if (bit_done) begin
          if (maj != parity_bit(9'(shreg), PARITY == PAR_ODD)) perr_n = 1'b1;
          state_n = ST_STOP;
        end
      end
      ST_STOP: begin
        if (bit_done) begin
          if (!maj) begin
            ferr_c   = 1'b1;
            bitidx_n = '0;
            state_n  = ST_BREAK;
          end else if (bitidx == STOP_LAST) begin
            accept_c = 1'b1;
            bitidx_n = '0;
            state_n  = ST_IDLE;
          end else begin
            bitidx_n = bitidx + IDX_W'(1);
          end
        end
      end
      ST_BREAK: begin
        if (irx) state_n = ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  // Output stage: accepted words land one clock after the final stop-bit decision.
  always_ff @(posedge clk) begin
    if (reset) begin
      accept_q       <= 1'b0;
      holdcnt        <= '0;
      bus.oData      <= '0;
      bus.oValid     <= 1'b0;
      bus.oParityErr <= 1'b0;
      bus.oFrameErr  <= 1'b0;
      bus.oBusy      <= 1'b0;
    end else begin
      accept_q      <= accept_c;
      bus.oFrameErr <= ferr_c;
      bus.oBusy     <= (state_n != ST_IDLE);
      if (accept_q) begin
        bus.oData      <= shreg;
        bus.oParityErr <= perr;
        bus.oValid     <= 1'b1;
        holdcnt        <= '0;
      end else if (bus.oValid) begin
        if (holdcnt == HOLD_LAST) begin
          bus.oValid <= 1'b0;
          holdcnt    <= '0;
        end else begin
          holdcnt <= holdcnt + HOLD_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Directed and randomized frame stimulus for uart_rx_cfg, checked against a
// frame-level model of the expected words, flags and timing.
module tb_uart_rx_cfg;

  localparam int unsigned DIV = 16;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        rx_line = 1'b1;
  int unsigned sel = 0;
  int unsigned cyc = 0;
  int unsigned t_fall = 0;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_rx_cfg_if #(.DATA_BITS(8)) bus0 ();
  uart_rx_cfg_if #(.DATA_BITS(8)) bus1 ();
  uart_rx_cfg_if #(.DATA_BITS(8)) bus2 ();

  assign bus0.RX = (sel == 0) ? rx_line : 1'b1;
  assign bus1.RX = (sel == 1) ? rx_line : 1'b1;
  assign bus2.RX = (sel == 2) ? rx_line : 1'b1;

  uart_rx_cfg #(.DIVIDER(DIV), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .VALID_HOLD(10))
    dut0 (.clk(clk), .reset(reset), .bus(bus0));
  uart_rx_cfg #(.DIVIDER(DIV), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1), .VALID_HOLD(10))
    dut1 (.clk(clk), .reset(reset), .bus(bus1));
  uart_rx_cfg #(.DIVIDER(DIV), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .VALID_HOLD(200))
    dut2 (.clk(clk), .reset(reset), .bus(bus2));

  // Observe whichever receiver is currently being driven.
  logic [7:0] m_data;
  logic       m_valid, m_perr, m_ferr, m_busy;
  always_comb begin
    case (sel)
      1: begin m_data = bus1.oData; m_valid = bus1.oValid; m_perr = bus1.oParityErr;
               m_ferr = bus1.oFrameErr; m_busy = bus1.oBusy; end
      2: begin m_data = bus2.oData; m_valid = bus2.oValid; m_perr = bus2.oParityErr;
               m_ferr = bus2.oFrameErr; m_busy = bus2.oBusy; end
      default: begin m_data = bus0.oData; m_valid = bus0.oValid; m_perr = bus0.oParityErr;
               m_ferr = bus0.oFrameErr; m_busy = bus0.oBusy; end
    endcase
  end

  int unsigned rise_cyc[$];
  logic [7:0]  got_data[$];
  logic        got_perr[$];
  int unsigned hold_len[$];
  int unsigned ferr_pulses = 0;
  int unsigned ferr_cycles = 0;
  int unsigned last_chg = 0;
  logic        p_valid = 1'b0;
  logic        p_ferr = 1'b0;
  logic [7:0]  p_data = 8'h00;

  always @(negedge clk) begin
    if (m_valid && !p_valid) begin
      rise_cyc.push_back(cyc);
      got_data.push_back(m_data);
      got_perr.push_back(m_perr);
      last_chg = cyc;
    end else if (m_valid && m_data != p_data) begin
      got_data.push_back(m_data);
      got_perr.push_back(m_perr);
      last_chg = cyc;
    end
    if (!m_valid && p_valid) hold_len.push_back(cyc - last_chg);
    if (m_ferr) ferr_cycles++;
    if (m_ferr && !p_ferr) ferr_pulses++;
    p_valid = m_valid;
    p_ferr  = m_ferr;
    p_data  = m_data;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int unsigned n);
    rx_line = 1'b1;
    repeat (n) step();
  endtask

  task automatic clear_mon();
    rise_cyc.delete();
    got_data.delete();
    got_perr.delete();
    hold_len.delete();
    ferr_pulses = 0;
    ferr_cycles = 0;
  endtask

  // First oValid cycle relative to the pin falling edge, from the frame length.
  function automatic int unsigned exp_latency(input int unsigned nbits, input int unsigned par_on,
                                              input int unsigned stops);
    return 2 + DIV / 2 + (nbits + par_on + stops) * DIV + 1;
  endfunction

  // par_bit < 0 omits the parity bit; spike_bit selects a frame bit that gets a
  // one-clock inverted spike at its seventh clock (-1 for none).
  task automatic send_frame(input logic [7:0] data, input int par_bit, input logic stop_val,
                            input int spike_bit);
    logic q[$];
    q.push_back(1'b0);
    for (int i = 0; i < 8; i++) q.push_back(data[i]);
    if (par_bit >= 0) q.push_back(par_bit[0]);
    q.push_back(stop_val);
    t_fall = cyc;
    for (int i = 0; i < q.size(); i++) begin
      rx_line = q[i];
      if (i == spike_bit) begin
        repeat (6) step();
        rx_line = ~q[i];
        step();
        rx_line = q[i];
        repeat (9) step();
      end else begin
        repeat (DIV) step();
      end
    end
  endtask

  task automatic expect_word(input string tag, input logic [7:0] d, input logic pe,
                             input int unsigned lat, input int unsigned hold);
    chk({tag, "_rises"}, rise_cyc.size(), 1);
    if (rise_cyc.size() == 1 && got_data.size() == 1) begin
      chk({tag, "_data"}, got_data[0], d);
      chk({tag, "_perr"}, got_perr[0], pe);
      if (lat != 0) chk({tag, "_latency"}, rise_cyc[0] - t_fall, lat);
    end
    if (hold_len.size() > 0) chk({tag, "_hold"}, hold_len[0], hold);
    else chk({tag, "_hold_seen"}, 0, 1);
  endtask

  initial begin
    logic [7:0] rd;
    logic       bad;
    int         pb;

    // Reset values
    repeat (3) step();
    chk("rst_data", m_data, 8'h00);
    chk("rst_valid", m_valid, 1'b0);
    chk("rst_perr", m_perr, 1'b0);
    chk("rst_ferr", m_ferr, 1'b0);
    chk("rst_busy", m_busy, 1'b0);
    reset = 1'b0;
    idle(20);

    // 8N1 word with default parameters
    sel = 0;
    clear_mon();
    send_frame(8'hA5, -1, 1'b1, -1);
    idle(40);
    expect_word("t1", 8'hA5, 1'b0, exp_latency(8, 0, 1), 10);
    chk("t1_no_ferr", ferr_pulses, 0);

    // Even parity: wrong then correct parity bit
    sel = 1;
    idle(5);
    clear_mon();
    send_frame(8'h3C, 1, 1'b1, -1);
    idle(40);
    expect_word("t2_bad", 8'h3C, 1'b1, exp_latency(8, 1, 1), 10);
    clear_mon();
    send_frame(8'h3C, 0, 1'b1, -1);
    idle(40);
    expect_word("t2_good", 8'h3C, 1'b0, exp_latency(8, 1, 1), 10);

    // Random words with randomly corrupted parity
    for (int n = 0; n < 6; n++) begin
      rd  = 8'($urandom_range(0, 255));
      bad = 1'($urandom_range(0, 1));
      pb  = int'(($countones(rd) % 2) ^ int'(bad));
      clear_mon();
      send_frame(rd, pb, 1'b1, -1);
      idle(40);
      expect_word("t2_rand", rd, bad, exp_latency(8, 1, 1), 10);
    end

    // Start-bit glitch while idle, then a spike inside a data bit
    sel = 0;
    idle(5);
    clear_mon();
    rx_line = 1'b0;
    repeat (5) step();
    rx_line = 1'b1;
    repeat (8) step();
    chk("t3_glitch_busy", m_busy, 1'b0);
    idle(40);
    chk("t3_glitch_rises", rise_cyc.size(), 0);
    clear_mon();
    send_frame(8'h00, -1, 1'b1, 4);
    idle(40);
    expect_word("t3_spike", 8'h00, 1'b0, exp_latency(8, 0, 1), 10);

    // Framing error followed by a held-low line
    clear_mon();
    send_frame(8'h55, -1, 1'b0, -1);
    repeat (100) step();
    chk("t4_break_busy", m_busy, 1'b1);
    rx_line = 1'b1;
    repeat (8) step();
    chk("t4_idle_busy", m_busy, 1'b0);
    chk("t4_ferr_pulses", ferr_pulses, 1);
    chk("t4_ferr_width", ferr_cycles, 1);
    chk("t4_rises", rise_cyc.size(), 0);
    chk("t4_data_kept", m_data, 8'h00);
    idle(20);
    clear_mon();
    send_frame(8'h81, -1, 1'b1, -1);
    idle(40);
    expect_word("t4_next", 8'h81, 1'b0, exp_latency(8, 0, 1), 10);

    // Back-to-back words during a long valid hold
    sel = 2;
    idle(5);
    clear_mon();
    send_frame(8'h11, -1, 1'b1, -1);
    send_frame(8'h22, -1, 1'b1, -1);
    send_frame(8'h33, -1, 1'b1, -1);
    idle(300);
    chk("t5_rises", rise_cyc.size(), 1);
    chk("t5_words", got_data.size(), 3);
    if (got_data.size() == 3) begin
      chk("t5_w0", got_data[0], 8'h11);
      chk("t5_w1", got_data[1], 8'h22);
      chk("t5_w2", got_data[2], 8'h33);
    end
    chk("t5_holds", hold_len.size(), 1);
    if (hold_len.size() == 1) chk("t5_hold_len", hold_len[0], 200);

    // Reset during data bit 4
    sel = 0;
    idle(5);
    clear_mon();
    fork
      send_frame(8'hF0, -1, 1'b1, -1);
      begin
        repeat (5 * DIV + 8) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("t6_rst_data", m_data, 8'h00);
        chk("t6_rst_valid", m_valid, 1'b0);
        chk("t6_rst_busy", m_busy, 1'b0);
        chk("t6_rst_ferr", m_ferr, 1'b0);
      end
    join
    idle(40);
    chk("t6_abandoned", rise_cyc.size(), 0);
    clear_mon();
    send_frame(8'hC3, -1, 1'b1, -1);
    idle(40);
    expect_word("t6_next", 8'hC3, 1'b0, exp_latency(8, 0, 1), 10);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
